adam_obi_ram_arbiter: RTL and testbench
=======================================

ADAM_OBI_RAM_ARBITER -- requirements
Module: adam_obi_ram_arbiter

Interface
REQ-001 Parameter NO_REQS, default 2: number of OBI requesters sharing the RAM port, legal 2..4.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.
REQ-004 Parameter RAM_LAT, default 1: fixed RAM response latency in cycles, legal 1..3.
REQ-005 Clock and reset arrive via an ADAM_SEQ.Slave port named seq: one clock (seq.clk) and a synchronous, active-high reset (seq.rst).
REQ-006 seq.clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 seq.rst  input  1  synchronous active-high reset.
REQ-008 req_i  input  NO_REQS  per-requester OBI request.
REQ-009 gnt_o  output  NO_REQS  per-requester grant; one-hot or zero.
REQ-010 addr_i/we_i/be_i/wdata_i  input  NO_REQS x (ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH)  per-requester command fields.
REQ-011 rvalid_o  output  NO_REQS  per-requester response valid.
REQ-012 rdata_o  output  DATA_WIDTH  response data, shared across requesters.
REQ-013 ram_req_o/ram_addr_o/ram_we_o/ram_be_o/ram_wdata_o  output  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  RAM command.
REQ-014 ram_rvalid_i  input  1; ram_rdata_i  input  DATA_WIDTH  RAM response.
REQ-015 pause_req_i  input  1; pause_ack_o  output  1  drain handshake.
REQ-016 err_o  output  1  sticky protocol-violation flag.

Function
REQ-017 RAM is always ready: an issued ram_req_o is accepted that cycle and the RAM returns exactly one ram_rvalid_i RAM_LAT cycles later, for reads and writes alike.
REQ-018 Arbitration is round-robin and combinational: the winner is the first asserted req_i searching upward (with wrap) from last_grant+1; gnt_o[winner]=1 the same cycle.
REQ-019 last_grant updates to the winner on each grant; with no request, it holds.
REQ-020 ram_req_o = 1 only when a grant is issued; ram_addr/we/be/wdata are the winner's fields; when no grant is issued they are zero.
REQ-021 An ownership pipeline of depth RAM_LAT, each stage {valid, id}, shifts every cycle; stage 0 loads {1, winner} on grant, else {0, x}.
REQ-022 rvalid_o[id] = ram_rvalid_i AND last-stage valid; all other rvalid_o bits are 0; rdata_o = ram_rdata_i when any rvalid_o is set, else zero.
REQ-023 Throughput: one grant per cycle sustained; back-to-back grants to the same or different requesters are legal.
REQ-024 Simultaneous grant and response in the same cycle are independent and both honoured.
REQ-025 Pause: while pause_req_i=1, gnt_o=0 and ram_req_o=0 from the same cycle; in-flight responses still route.
REQ-026 pause_ack_o is registered: it rises the cycle after pause_req_i=1 and the pipeline holds no valid stage; it falls the cycle after pause_req_i=0.
REQ-027 err_o sets when ram_rvalid_i=1 with last stage invalid, or last stage valid with ram_rvalid_i=0; it stays set until reset.
REQ-028 Requests arriving during pause remain pending at the requester (OBI holds req); the arbiter keeps no request memory.

Reset
REQ-029 Reset values: last_grant=NO_REQS-1 (requester 0 wins first), all pipeline stages invalid, pause_ack_o=0, err_o=0.
REQ-030 During reset, gnt_o, ram_req_o, rvalid_o and rdata_o are 0; responses in flight at reset are discarded without setting err_o.

Verification
REQ-031 Reset, then req_i=2'b11 for 4 cycles -> gnt_o sequence 01,10,01,10; RAM addresses alternate A0,A1.
REQ-032 RAM_LAT=2, grant req0 read at cycle t with rdata 0xDEADBEEF -> rvalid_o=2'b01 and rdata_o=0xDEADBEEF at t+2 only.
REQ-033 req1 alone for 3 cycles, then req0 and req1 together -> req0 granted first (last_grant=1).
REQ-034 Grant at t (RAM_LAT=1), pause_req_i=1 at t+1 with req_i=2'b11 -> gnt_o=0, rvalid_o routed at t+1, pause_ack_o=1 at t+2; pause_req_i=0 -> ack=0 next cycle and grants resume.
REQ-035 ram_rvalid_i pulsed with pipeline empty -> err_o=1, held until seq.rst.
REQ-036 Reset asserted one cycle after a grant -> no rvalid_o, err_o=0 after reset release.

Source files
------------

// File: rtl/adam_obi_ram_arbiter_if.sv
// Clock/reset bundle and the requester/RAM bus bundle of the OBI RAM arbiter.
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport Master (output clk, rst);
  modport Slave  (input  clk, rst);
endinterface

interface adam_obi_ram_arbiter_if #(
  parameter int unsigned NO_REQS    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [NO_REQS-1:0]                 req_i;
  logic [NO_REQS-1:0]                 gnt_o;
  logic [NO_REQS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NO_REQS-1:0]                 we_i;
  logic [NO_REQS-1:0][STRB_WIDTH-1:0] be_i;
  logic [NO_REQS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NO_REQS-1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]              rdata_o;

  logic                               ram_req_o;
  logic [ADDR_WIDTH-1:0]              ram_addr_o;
  logic                               ram_we_o;
  logic [STRB_WIDTH-1:0]              ram_be_o;
  logic [DATA_WIDTH-1:0]              ram_wdata_o;
  logic                               ram_rvalid_i;
  logic [DATA_WIDTH-1:0]              ram_rdata_i;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, ram_rvalid_i, ram_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
           ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, ram_rvalid_i, ram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
           ram_req_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o
  );
endinterface

// File: rtl/adam_obi_ram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, always-ready RAM port among
// several OBI requesters, with response routing, drain handshake and error flag.
module adam_obi_ram_arbiter #(
  parameter int unsigned NO_REQS    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_LAT    = 1
) (
  ADAM_SEQ.Slave                  seq,
  adam_obi_ram_arbiter_if.slave   bus,
  input  logic                    pause_req_i,
  output logic                    pause_ack_o,
  output logic                    err_o
);

  localparam int unsigned ID_W = $clog2(NO_REQS);

  logic [ID_W-1:0]              last_grant;
  logic [ID_W-1:0]              winner;
  logic                         found;
  logic                         grant;
  logic                         resp;
  logic [RAM_LAT-1:0]           pipe_valid;
  logic [RAM_LAT-1:0]           pipe_valid_next;
  logic [RAM_LAT-1:0][ID_W-1:0] pipe_id;

  // First asserted request searching upward from last_grant+1, wrapping once.
  always_comb begin : arbitrate
    int unsigned idx;
    logic [ID_W-1:0] cand;
    idx    = 0;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NO_REQS; i++) begin
      idx = 32'(last_grant) + 32'd1 + i;
      if (idx >= NO_REQS) idx = idx - NO_REQS;
      cand = ID_W'(idx);
      if (!found && bus.req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant = found && !pause_req_i && !seq.rst;
  assign resp  = bus.ram_rvalid_i && pipe_valid[RAM_LAT-1] && !seq.rst;

  always_comb begin
    bus.gnt_o       = '0;
    bus.ram_req_o   = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = '0;
    bus.ram_wdata_o = '0;
    if (grant) begin
      bus.gnt_o[winner] = 1'b1;
      bus.ram_req_o     = 1'b1;
      bus.ram_addr_o    = bus.addr_i[winner];
      bus.ram_we_o      = bus.we_i[winner];
      bus.ram_be_o      = bus.be_i[winner];
      bus.ram_wdata_o   = bus.wdata_i[winner];
    end
  end

  always_comb begin
    bus.rvalid_o = '0;
    bus.rdata_o  = '0;
    if (resp) begin
      bus.rvalid_o[pipe_id[RAM_LAT-1]] = 1'b1;
      bus.rdata_o                      = bus.ram_rdata_i;
    end
  end

  always_comb begin
    pipe_valid_next    = '0;
    pipe_valid_next[0] = grant;
    for (int unsigned i = 1; i < RAM_LAT; i++) begin
      pipe_valid_next[i] = pipe_valid[i-1];
    end
  end

  // Ack looks at the post-shift pipeline so it rises as soon as the last
  // in-flight response is being delivered.
  always_ff @(posedge seq.clk) begin
    if (seq.rst) begin
      last_grant  <= ID_W'(NO_REQS - 1);
      pipe_valid  <= '0;
      pipe_id     <= '0;
      pause_ack_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if (grant) last_grant <= winner;
      pipe_valid <= pipe_valid_next;
      pipe_id[0] <= winner;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        pipe_id[i] <= pipe_id[i-1];
      end
      pause_ack_o <= pause_req_i && !(|pipe_valid_next);
      if (bus.ram_rvalid_i != pipe_valid[RAM_LAT-1]) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adam_obi_ram_arbiter.sv
// Scoreboard bench for adam_obi_ram_arbiter (2 requesters, RAM latency 2).
module tb_adam_obi_ram_arbiter;

  localparam int unsigned LAT = 2;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [31:0] data;
  } rsp_t;

  ADAM_SEQ seq ();
  adam_obi_ram_arbiter_if #(.NO_REQS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  logic pause_req;
  logic pause_ack;
  logic err;
  logic inject;

  adam_obi_ram_arbiter #(
    .NO_REQS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_LAT(LAT)
  ) dut (
    .seq         (seq),
    .bus         (bus),
    .pause_req_i (pause_req),
    .pause_ack_o (pause_ack),
    .err_o       (err)
  );

  // Per-requester command fields and the RAM contents they map to.
  logic [31:0] addr_tab  [2] = '{32'h0000_0100, 32'h0000_0200};
  logic [31:0] wdata_tab [2] = '{32'h1111_1111, 32'h2222_2222};
  logic        we_tab    [2] = '{1'b0, 1'b1};
  logic [31:0] data_tab  [2] = '{32'hDEAD_BEEF, 32'hCAFE_0200};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t g;
  rsp_t r;

  initial seq.clk = 1'b0;
  always #5 seq.clk = ~seq.clk;
  always @(posedge seq.clk) cyc <= cyc + 1;

  // RAM model: always ready, answers every command LAT cycles later.
  logic [LAT-1:0]        dly_v = '0;
  logic [LAT-1:0][31:0]  dly_d = '0;
  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hCAFE_0000);
  endfunction
  always @(posedge seq.clk) begin
    dly_v <= {dly_v[LAT-2:0], bus.ram_req_o};
    dly_d <= {dly_d[LAT-2:0], ram_data(bus.ram_addr_o)};
  end
  assign bus.ram_rvalid_i = dly_v[LAT-1] | inject;
  assign bus.ram_rdata_i  = dly_d[LAT-1];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle; queue the expected grant and, optionally, its response.
  task automatic step(input logic [1:0] req, input logic pause,
                      input logic [1:0] exp_gnt, input bit push_rsp);
    int idx;
    bus.req_i = req;
    pause_req = pause;
    if (exp_gnt != 2'b00) begin
      idx = exp_gnt[1] ? 1 : 0;
      gq.push_back('{cyc, exp_gnt, addr_tab[idx], we_tab[idx], wdata_tab[idx]});
      if (push_rsp) rq.push_back('{cyc + LAT, exp_gnt, data_tab[idx]});
    end
    @(posedge seq.clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 2'b00, 1'b0);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectations.
  always @(negedge seq.clk) begin
    if (bus.gnt_o != 2'b00) begin
      if (gq.size() == 0) chk("gnt_unexpected", 96'(bus.gnt_o), 96'd0);
      else begin
        g = gq.pop_front();
        chk("gnt_cycle", 96'(cyc), 96'(g.cyc));
        chk("gnt_vec", 96'(bus.gnt_o), 96'(g.gnt));
        chk("ram_cmd",
            96'({bus.ram_req_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o}),
            96'({1'b1, g.we, 4'hF, g.addr, g.wdata}));
      end
    end else begin
      chk("ram_idle",
          96'({bus.ram_req_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o}),
          96'd0);
    end
    if (bus.rvalid_o != 2'b00) begin
      if (rq.size() == 0) chk("rvalid_unexpected", 96'(bus.rvalid_o), 96'd0);
      else begin
        r = rq.pop_front();
        chk("rsp_cycle", 96'(cyc), 96'(r.cyc));
        chk("rsp_vec", 96'(bus.rvalid_o), 96'(r.rv));
        chk("rsp_data", 96'(bus.rdata_o), 96'(r.data));
      end
    end else begin
      chk("rdata_idle", 96'(bus.rdata_o), 96'd0);
    end
  end

  initial begin
    seq.rst     = 1'b1;
    pause_req   = 1'b0;
    inject      = 1'b0;
    bus.req_i   = 2'b00;
    bus.be_i    = '1;
    for (int i = 0; i < 2; i++) begin
      bus.addr_i[i]  = addr_tab[i];
      bus.wdata_i[i] = wdata_tab[i];
      bus.we_i[i]    = we_tab[i];
    end
    @(posedge seq.clk);
    #1;

    // Reset with requests pending: nothing may be granted.
    step(2'b11, 1'b0, 2'b00, 1'b0);
    step(2'b11, 1'b0, 2'b00, 1'b0);
    chk("rst_gnt", 96'(bus.gnt_o), 96'd0);
    chk("rst_ack_err", 96'({pause_ack, err}), 96'd0);
    seq.rst = 1'b0;

    // Both requesting: alternate starting with requester 0.
    step(2'b11, 1'b0, 2'b01, 1'b1);
    step(2'b11, 1'b0, 2'b10, 1'b1);
    step(2'b11, 1'b0, 2'b01, 1'b1);
    step(2'b11, 1'b0, 2'b10, 1'b1);
    idle(3);

    // Requester 1 alone back-to-back, then both: requester 0 wins.
    step(2'b10, 1'b0, 2'b10, 1'b1);
    step(2'b10, 1'b0, 2'b10, 1'b1);
    step(2'b10, 1'b0, 2'b10, 1'b1);
    step(2'b11, 1'b0, 2'b01, 1'b1);
    idle(3);

    // Single read of 0xDEADBEEF, response exactly LAT cycles later.
    step(2'b01, 1'b0, 2'b01, 1'b1);
    idle(3);

    // Pause with one read in flight; ack once drained, grants resume after.
    step(2'b01, 1'b0, 2'b01, 1'b1);
    chk("ack_before_pause", 96'(pause_ack), 96'd0);
    step(2'b11, 1'b1, 2'b00, 1'b0);
    chk("ack_inflight", 96'(pause_ack), 96'd0);
    step(2'b11, 1'b1, 2'b00, 1'b0);
    chk("ack_drained", 96'(pause_ack), 96'd1);
    step(2'b11, 1'b1, 2'b00, 1'b0);
    chk("ack_held", 96'(pause_ack), 96'd1);
    step(2'b11, 1'b0, 2'b10, 1'b1);
    chk("ack_fall", 96'(pause_ack), 96'd0);
    step(2'b11, 1'b0, 2'b01, 1'b1);
    idle(3);
    chk("err_clean_traffic", 96'(err), 96'd0);

    // Stray RAM response with empty pipeline: sticky error until reset.
    inject = 1'b1;
    step(2'b00, 1'b0, 2'b00, 1'b0);
    inject = 1'b0;
    chk("err_set", 96'(err), 96'd1);
    idle(2);
    chk("err_sticky", 96'(err), 96'd1);
    seq.rst = 1'b1;
    idle(2);
    seq.rst = 1'b0;
    chk("err_cleared", 96'(err), 96'd0);

    // Reset right after a grant: its response is dropped silently.
    step(2'b01, 1'b0, 2'b01, 1'b0);
    seq.rst = 1'b1;
    idle(2);
    seq.rst = 1'b0;
    idle(2);
    chk("err_after_rst_drop", 96'(err), 96'd0);

    // Arbitration pointer restarts at requester 0 after reset.
    step(2'b11, 1'b0, 2'b01, 1'b1);
    idle(4);

    chk("gnt_queue_drained", 96'(gq.size()), 96'd0);
    chk("rsp_queue_drained", 96'(rq.size()), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
